// File: rtl/imm_pkg.sv
// imm_pkg: immediate format enum, stage occupancy states and RV opcode constants
package imm_pkg;
  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SHAMT, IMM_Z} imm_type_e;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_e;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam logic [6:0] FENCE  = 7'b0001111;
endpackage

// File: rtl/imm_gen_stage_if.sv
// imm_gen_stage_if: fetch-side input and decode-side output handshake bundle
//   in_valid/in_ready/in_inst/in_tag : upstream instruction stream
//   out_valid/out_ready/out_*        : decoded stream towards decode
//   master = upstream/downstream driver side, slave = the stage itself
interface imm_gen_stage_if #(parameter int XLEN = 32, parameter int TAG_W = 32);
  import imm_pkg::*;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_inst;
  logic [TAG_W-1:0] out_tag;
  logic [XLEN-1:0]  out_imm;
  imm_type_e        out_type;
  logic             out_illegal;
  modport master (
    output in_valid, in_inst, in_tag, out_ready,
    input  in_ready, out_valid, out_inst, out_tag, out_imm, out_type, out_illegal
  );
  modport slave (
    input  in_valid, in_inst, in_tag, out_ready,
    output in_ready, out_valid, out_inst, out_tag, out_imm, out_type, out_illegal
  );
endinterface

// File: rtl/imm_decode_core.sv
// imm_decode_core: combinational inst -> extended immediate, format and illegal-opcode flag
//   inst    : raw 32-bit instruction
//   imm     : immediate extended to XLEN
//   typ     : immediate format
//   illegal : opcode outside the supported set
module imm_decode_core import imm_pkg::*; #(
  parameter int XLEN    = 32,
  parameter int EN_ZIMM = 1
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output imm_type_e       typ,
  output logic            illegal
);
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh, imm_z;
  assign opc    = inst[6:0];
  assign f3     = inst[14:12];
  assign imm_i  = XLEN'($signed(inst[31:20]));
  assign imm_s  = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign imm_b  = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign imm_u  = XLEN'($signed({inst[31:12], 12'b0}));
  assign imm_j  = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
  assign imm_sh = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
  assign imm_z  = XLEN'(inst[19:15]);
  always_comb begin
    typ     = IMM_NONE;
    illegal = 1'b0;
    case (opc)
      OP_IMM:      typ = (f3[1:0] == 2'b01) ? IMM_SHAMT : IMM_I;
      LOAD, JALR:  typ = IMM_I;
      STORE:       typ = IMM_S;
      BRANCH:      typ = IMM_B;
      LUI, AUIPC:  typ = IMM_U;
      JAL:         typ = IMM_J;
      SYSTEM:      typ = ((EN_ZIMM != 0) && f3[2]) ? IMM_Z : IMM_NONE;
      OP, FENCE:   typ = IMM_NONE;
      default:     illegal = 1'b1;
    endcase
  end
  assign imm = (typ == IMM_I)     ? imm_i  :
               (typ == IMM_S)     ? imm_s  :
               (typ == IMM_B)     ? imm_b  :
               (typ == IMM_U)     ? imm_u  :
               (typ == IMM_J)     ? imm_j  :
               (typ == IMM_SHAMT) ? imm_sh :
               (typ == IMM_Z)     ? imm_z  : '0;
endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered immediate-generation stage with a 2-entry skid buffer
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, drops every buffered entry
//   flush : synchronous discard of all buffered entries (and a same-cycle accept)
//   bus   : slave side of imm_gen_stage_if (in_* accept, out_* emit)
module imm_gen_stage import imm_pkg::*; #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 32,
  parameter int EN_ZIMM = 1
) (
  input logic            clk,
  input logic            rst_n,
  input logic            flush,
  imm_gen_stage_if.slave bus
);
  typedef struct packed {
    logic [31:0]      inst;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  imm;
    imm_type_e        typ;
    logic             illegal;
  } entry_t;
  occ_e            state, state_d;
  entry_t          head, skid, new_e;
  logic [XLEN-1:0] dec_imm;
  imm_type_e       dec_typ;
  logic            dec_ill;
  logic            rdy_q, accept, fire, ld_new, ld_skid, ld_skid_new;
  imm_decode_core #(.XLEN(XLEN), .EN_ZIMM(EN_ZIMM)) u_dec (
    .inst    (bus.in_inst),
    .imm     (dec_imm),
    .typ     (dec_typ),
    .illegal (dec_ill)
  );
  assign new_e  = '{inst: bus.in_inst, tag: bus.in_tag, imm: dec_imm, typ: dec_typ, illegal: dec_ill};
  assign accept = bus.in_valid && rdy_q;
  assign fire   = bus.out_valid && bus.out_ready;
  // head always holds the oldest entry; skid only fills when head is stalled
  always_comb begin
    state_d     = state;
    ld_new      = 1'b0;
    ld_skid     = 1'b0;
    ld_skid_new = 1'b0;
    if (flush) state_d = EMPTY;
    else
      case (state)
        EMPTY: begin
          state_d = accept ? ONE : EMPTY;
          ld_new  = accept;
        end
        ONE: begin
          state_d     = (accept && !fire) ? FULL : (fire && !accept) ? EMPTY : ONE;
          ld_new      = accept && fire;
          ld_skid_new = accept && !fire;
        end
        FULL: begin
          state_d = fire ? ONE : FULL;
          ld_skid = fire;
        end
        default: state_d = EMPTY;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= EMPTY;
      rdy_q <= 1'b1;
      head  <= '0;
      skid  <= '0;
    end else begin
      state <= state_d;
      rdy_q <= (state_d != FULL);
      head  <= ld_new ? new_e : ld_skid ? skid : head;
      skid  <= ld_skid_new ? new_e : skid;
    end
  assign bus.in_ready    = rdy_q;
  assign bus.out_valid   = (state != EMPTY);
  assign bus.out_inst    = head.inst;
  assign bus.out_tag     = head.tag;
  assign bus.out_imm     = head.imm;
  assign bus.out_type    = head.typ;
  assign bus.out_illegal = head.illegal;
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: directed and random stimulus on XLEN=32 and XLEN=64 stages against a queue model
module tb_imm_gen_stage;
  import imm_pkg::*;
  typedef struct {
    logic [31:0] inst;
    logic [31:0] tag;
  } word_t;
  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  flush = 1'b0;
  int    n_chk = 0;
  int    n_fail = 0;
  word_t q[$];
  logic [6:0] opc_tab [13] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17,
                               7'h6F, 7'h33, 7'h73, 7'h0F, 7'h7F, 7'h0B};
  imm_gen_stage_if #(.XLEN(32), .TAG_W(32)) b32 ();
  imm_gen_stage_if #(.XLEN(64), .TAG_W(32)) b64 ();
  imm_gen_stage #(.XLEN(32), .TAG_W(32), .EN_ZIMM(1)) dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32));
  imm_gen_stage #(.XLEN(64), .TAG_W(32), .EN_ZIMM(0)) dut64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic longint sx(input longint u, input int n);
    return (u >= (longint'(1) << (n - 1))) ? u - (longint'(1) << n) : u;
  endfunction
  // immediate value as a plain integer, assembled from the instruction fields
  function automatic void ref_dec(input logic [31:0] i, input bit x64, input bit ez,
                                  output longint v, output int t, output bit ill);
    longint u;
    v = 0; t = 0; ill = 0;
    case (i[6:0])
      7'h13, 7'h03, 7'h67:
        if (i[6:0] == 7'h13 && (i[14:12] == 3'b001 || i[14:12] == 3'b101)) begin
          t = 6;
          v = x64 ? longint'(i[25:20]) : longint'(i[24:20]);
        end else begin
          t = 1; u = i[31:20]; v = sx(u, 12);
        end
      7'h23: begin t = 2; u = i[31:25] * 32 + i[11:7]; v = sx(u, 12); end
      7'h63: begin t = 3; u = i[11:8] * 2 + i[30:25] * 32 + i[7] * 2048 + i[31] * 4096; v = sx(u, 13); end
      7'h37, 7'h17: begin t = 4; u = longint'(i[31:12]) * 4096; v = sx(u, 32); end
      7'h6F: begin t = 5; u = i[30:21] * 2 + i[20] * 2048 + i[19:12] * 4096 + i[31] * (1 << 20); v = sx(u, 21); end
      7'h33, 7'h0F: t = 0;
      7'h73: if (ez && i[14]) begin t = 7; v = i[19:15]; end
      default: ill = 1;
    endcase
  endfunction
  task automatic check_all();
    longint v;
    int     t;
    bit     ill;
    chk("valid32", b32.out_valid, q.size() > 0);
    chk("ready32", b32.in_ready, q.size() < 2);
    chk("valid64", b64.out_valid, q.size() > 0);
    chk("ready64", b64.in_ready, q.size() < 2);
    if (q.size() > 0) begin
      ref_dec(q[0].inst, 1'b0, 1'b1, v, t, ill);
      chk("inst32", b32.out_inst, q[0].inst);
      chk("tag32", b32.out_tag, q[0].tag);
      chk("imm32", b32.out_imm, 64'(v[31:0]));
      chk("type32", b32.out_type, t);
      chk("ill32", b32.out_illegal, ill);
      ref_dec(q[0].inst, 1'b1, 1'b0, v, t, ill);
      chk("inst64", b64.out_inst, q[0].inst);
      chk("tag64", b64.out_tag, q[0].tag);
      chk("imm64", b64.out_imm, v);
      chk("type64", b64.out_type, t);
      chk("ill64", b64.out_illegal, ill);
    end
  endtask
  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] t, input logic r, input logic f);
    b32.in_valid = v; b32.in_inst = i; b32.in_tag = t; b32.out_ready = r;
    b64.in_valid = v; b64.in_inst = i; b64.in_tag = t; b64.out_ready = r;
    flush = f;
  endtask
  task automatic step(input logic v, input logic [31:0] i, input logic [31:0] t, input logic r, input logic f);
    bit acc, fir;
    drive(v, i, t, r, f);
    @(posedge clk);
    acc = v && (q.size() < 2);
    fir = (q.size() > 0) && r;
    if (f) q.delete();
    else begin
      if (fir) void'(q.pop_front());
      if (acc) q.push_back('{i, t});
    end
    #1 check_all();
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_v32"}, b32.out_valid, 1'b0);
    chk({tag, "_r32"}, b32.in_ready, 1'b1);
    chk({tag, "_v64"}, b64.out_valid, 1'b0);
    chk({tag, "_r64"}, b64.in_ready, 1'b1);
    chk({tag, "_inst"}, b32.out_inst, 32'h0);
    chk({tag, "_imm"}, b64.out_imm, 64'h0);
    chk({tag, "_type"}, b32.out_type, 3'd0);
    chk({tag, "_ill"}, b32.out_illegal, 1'b0);
  endtask
  initial begin
    logic [31:0] a, b, c, ri;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #12;
    chk_reset("rst");
    rst_n = 1'b1;
    step(1'b1, 32'hFFF00093, 32'h100, 1'b1, 1'b0);
    chk("t1_imm", b32.out_imm, 64'hFFFFFFFF);
    chk("t1_type", b32.out_type, IMM_I);
    step(1'b1, 32'h80000037, 32'h104, 1'b1, 1'b0);
    chk("t2_lui", b64.out_imm, 64'hFFFFFFFF80000000);
    chk("t2_ltype", b64.out_type, IMM_U);
    step(1'b1, 32'h40305093, 32'h108, 1'b1, 1'b0);
    chk("t2_srai", b64.out_imm, 64'd3);
    chk("t2_stype", b64.out_type, IMM_SHAMT);
    step(1'b1, 32'hFE000EE3, 32'h10C, 1'b1, 1'b0);
    chk("t3_b", b32.out_imm, 64'hFFFFFFFC);
    step(1'b1, 32'h0080006F, 32'h110, 1'b1, 1'b0);
    chk("t3_j", b32.out_imm, 64'd8);
    step(1'b1, 32'h0000007F, 32'h114, 1'b1, 1'b0);
    chk("t3_ill", b32.out_illegal, 1'b1);
    chk("t3_illimm", b32.out_imm, 64'd0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    a = 32'h00500113; b = 32'h00112023; c = 32'h00000463;
    step(1'b1, a, 32'h200, 1'b0, 1'b0);
    step(1'b1, b, 32'h204, 1'b0, 1'b0);
    step(1'b1, c, 32'h208, 1'b0, 1'b0);
    chk("t4_rdy", b32.in_ready, 1'b0);
    chk("t4_head", b32.out_inst, a);
    step(1'b1, c, 32'h208, 1'b0, 1'b0);
    chk("t4_stable", b32.out_inst, a);
    step(1'b1, c, 32'h208, 1'b1, 1'b0);
    chk("t4_second", b32.out_inst, b);
    step(1'b1, c, 32'h208, 1'b1, 1'b0);
    chk("t4_third", b32.out_inst, c);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("t4_drained", b32.out_valid, 1'b0);
    step(1'b1, a, 32'h300, 1'b0, 1'b0);
    step(1'b1, b, 32'h304, 1'b0, 1'b0);
    step(1'b1, c, 32'h308, 1'b0, 1'b1);
    chk("t5_valid", b32.out_valid, 1'b0);
    chk("t5_rdy", b32.in_ready, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b1, a, 32'h400, 1'b0, 1'b0);
    step(1'b1, b, 32'h404, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1 chk_reset("t6");
    q.delete();
    #1 rst_n = 1'b1;
    step(1'b1, c, 32'h408, 1'b1, 1'b0);
    chk("t6_first", b32.out_inst, c);
    for (int n = 0; n < 400; n++) begin
      ri = $urandom();
      ri[6:0] = opc_tab[$urandom_range(0, 12)];
      step($urandom_range(0, 9) < 7, ri, $urandom(), $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
